// File: rtl/vga_vram_sram_ctrl.sv
// VRAM back end: serves VGA pixel reads from a 16-bit async SRAM with a fixed
// 3-cycle latency and drains a small host write FIFO into read gaps.
module vga_vram_sram_ctrl #(
    parameter int PWIDTH      = 8,
    parameter int AWIDTH      = 19,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk_core,
    input  logic              rst_core,
    input  logic              vram_rd,
    input  logic [AWIDTH-1:0] vram_addr,
    output logic              vram_busy,
    output logic [PWIDTH-1:0] vram_data,
    output logic              vram_vld,
    input  logic              host_wr,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [PWIDTH-1:0] host_wdata,
    output logic              host_ready,
    output logic [AWIDTH-2:0] sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int PW = $clog2(WFIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WGAP, WR0, WR1} state_t;

    state_t state, next_state;

    logic [AWIDTH-1:0] fifo_addr [WFIFO_DEPTH];
    logic [PWIDTH-1:0] fifo_data [WFIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              fifo_empty, fifo_full, push, pop, rd_acc;
    logic [AWIDTH-1:0] head_addr;
    logic [PWIDTH-1:0] head_data;

    logic              dq_oe;
    logic [15:0]       dq_out;

    logic              rd_s0, sel_s0, cap_vld, mid_vld;
    logic [PWIDTH-1:0] cap_byte, mid_byte;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(WFIFO_DEPTH));
    assign host_ready = ~fifo_full;
    assign push       = host_wr & host_ready;
    assign rd_acc     = vram_rd & ~vram_busy;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign pop        = (next_state == WR0);

    assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!rd_acc)        next_state = WR0;
                    else if (fifo_full) next_state = WGAP;
                end
            end
            WGAP:    next_state = WR0;
            WR0:     next_state = WR1;
            WR1:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: FIFO storage has no reset; count and pointers alone define its contents.
    always_ff @(posedge clk_core) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_addr;
            fifo_data[wr_ptr] <= host_wdata;
        end
        if (pop) dq_out <= {head_data, head_data};
    end

    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // SRAM bus: an accepted read owns the cycle after acceptance; writes take WR0/WR1.
    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            state     <= IDLE;
            vram_busy <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            dq_oe     <= 1'b0;
        end else begin
            state     <= next_state;
            vram_busy <= (next_state != IDLE);
            if (rd_acc) begin
                sram_addr <= vram_addr[AWIDTH-1:1];
                sram_ce_n <= 1'b0;
                sram_oe_n <= 1'b0;
                sram_we_n <= 1'b1;
                sram_ub_n <= 1'b0;
                sram_lb_n <= 1'b0;
                dq_oe     <= 1'b0;
            end else if (next_state == WR0) begin
                sram_addr <= head_addr[AWIDTH-1:1];
                sram_ce_n <= 1'b0;
                sram_oe_n <= 1'b1;
                sram_we_n <= 1'b0;
                sram_lb_n <= head_addr[0];
                sram_ub_n <= ~head_addr[0];
                dq_oe     <= 1'b1;
            end else if (next_state == WR1) begin
                // Address, data and byte enables stay put for write hold time.
                sram_we_n <= 1'b1;
            end else begin
                sram_ce_n <= 1'b1;
                sram_oe_n <= 1'b1;
                sram_we_n <= 1'b1;
                sram_ub_n <= 1'b1;
                sram_lb_n <= 1'b1;
                dq_oe     <= 1'b0;
            end
        end
    end

    // Read return pipeline: sample the bus at the end of the read cycle, then two stages.
    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            rd_s0     <= 1'b0;
            sel_s0    <= 1'b0;
            cap_vld   <= 1'b0;
            cap_byte  <= '0;
            mid_vld   <= 1'b0;
            mid_byte  <= '0;
            vram_vld  <= 1'b0;
            vram_data <= '0;
        end else begin
            rd_s0    <= rd_acc;
            sel_s0   <= vram_addr[0];
            cap_vld  <= rd_s0;
            cap_byte <= sel_s0 ? sram_dq[15:8] : sram_dq[7:0];
            mid_vld  <= cap_vld;
            mid_byte <= cap_byte;
            vram_vld <= mid_vld;
            if (mid_vld) vram_data <= mid_byte;
        end
    end

endmodule

// File: tb/tb_vga_vram_sram_ctrl.sv
// Bench for vga_vram_sram_ctrl: SRAM device model, pixel-level reference memory
// and a read scoreboard checking data, order and 3-cycle latency.
module tb_vga_vram_sram_ctrl;

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b0;
    logic        vram_rd = 1'b0;
    logic [18:0] vram_addr = '0;
    logic        vram_busy;
    logic [7:0]  vram_data;
    logic        vram_vld;
    logic        host_wr = 1'b0;
    logic [18:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    vga_vram_sram_ctrl #(.PWIDTH(8), .AWIDTH(19), .WFIFO_DEPTH(4)) dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr),
        .vram_busy (vram_busy),
        .vram_data (vram_data),
        .vram_vld  (vram_vld),
        .host_wr   (host_wr),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_ready(host_ready),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    always #5 clk_core = ~clk_core;

    // SRAM device model plus a bus keeper enabled only while checking that the controller floats dq.
    logic [15:0] sram_mem [0:262143];
    logic        float_chk = 1'b0;

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;
    assign sram_dq = float_chk ? 16'h0000 : 16'hzzzz;

    always @(posedge clk_core) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pixel contents as the host sees them (written pixels override the power-up pattern).
    logic [7:0] shadow [int];

    function automatic logic [15:0] init_word(input logic [17:0] w);
        return 16'(w * 7919) ^ 16'hC35A;
    endfunction

    function automatic logic [7:0] exp_pix(input logic [18:0] a);
        logic [15:0] w;
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        w = init_word(a[18:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    typedef struct {
        logic [7:0] exp;
        int         cyc;
    } rd_t;

    rd_t exp_q[$];
    int  cyc = 0;

    always @(posedge clk_core) begin
        if (rst_core) begin
            cyc++;
            if (vram_rd && !vram_busy) exp_q.push_back('{exp_pix(vram_addr), cyc});
            if (host_wr && host_ready) shadow[int'(host_addr)] = host_wdata;
        end
    end

    always @(negedge clk_core) begin
        if (rst_core && vram_vld) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL vld_unexpected: vram_vld=1 with no outstanding read at %0t", $time);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                check("rd_data", 32'(vram_data), 32'(e.exp));
                check("rd_latency", 32'(cyc - e.cyc), 32'd3);
            end
        end
    end

    task automatic do_read(input logic [18:0] a);
        vram_rd   = 1'b1;
        vram_addr = a;
        @(negedge clk_core);
        vram_rd   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk_core);
        check("reads_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [18:0] addr;
        logic [15:0] word;
        logic [7:0]  exp;
    } vec_t;

    vec_t        vecs[6];
    logic [18:0] wr_list[$];
    logic [18:0] t6_addr[3];
    logic [3:0]  busy_seq, we_seq, rdy_seq;
    int          hit;

    initial begin
        for (int w = 0; w < 262144; w++) sram_mem[w] = init_word(18'(w));

        vecs[0] = '{19'h00005, 16'hA55A, 8'hA5};
        vecs[1] = '{19'h00004, 16'hA55A, 8'h5A};
        vecs[2] = '{19'h00000, 16'h1234, 8'h34};
        vecs[3] = '{19'h7FFFF, 16'hBEEF, 8'hBE};
        vecs[4] = '{19'h7FFFE, 16'hBEEF, 8'hEF};
        vecs[5] = '{19'h40001, 16'h00FF, 8'h00};

        // Reset state with the bus floated.
        float_chk = 1'b1;
        repeat (3) @(negedge clk_core);
        check("rst_busy", 32'(vram_busy), 32'd0);
        check("rst_vld", 32'(vram_vld), 32'd0);
        check("rst_data", 32'(vram_data), 32'd0);
        check("rst_ready", 32'(host_ready), 32'd1);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rst_dq_float", 32'(sram_dq), 32'd0);
        rst_core = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_core);
            check("idle_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        end
        float_chk = 1'b0;

        // Single reads from preloaded words: latency, byte select, data hold.
        for (int i = 0; i < 6; i++) begin
            sram_mem[vecs[i].addr[18:1]] = vecs[i].word;
            shadow[int'({vecs[i].addr[18:1], 1'b0})] = vecs[i].word[7:0];
            shadow[int'({vecs[i].addr[18:1], 1'b1})] = vecs[i].word[15:8];
            do_read(vecs[i].addr);
            for (int k = 0; k < 2; k++) begin
                check("vec_vld_early", 32'(vram_vld), 32'd0);
                @(negedge clk_core);
            end
            check("vec_vld_early", 32'(vram_vld), 32'd0);
            @(negedge clk_core);
            check("vec_vld", 32'(vram_vld), 32'd1);
            check("vec_data", 32'(vram_data), 32'(vecs[i].exp));
            @(negedge clk_core);
            check("vec_vld_pulse", 32'(vram_vld), 32'd0);
            check("vec_data_hold", 32'(vram_data), 32'(vecs[i].exp));
        end

        // Host write into an idle controller.
        host_wr = 1'b1; host_addr = 19'h00004; host_wdata = 8'h3C;
        @(negedge clk_core);
        host_wr = 1'b0;
        check("wr_busy_pre", 32'(vram_busy), 32'd0);
        @(negedge clk_core);
        check("wr0_busy", 32'(vram_busy), 32'd1);
        check("wr0_addr", 32'(sram_addr), 32'h2);
        check("wr0_dq", 32'(sram_dq), 32'h3C3C);
        check("wr0_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'b01010);
        @(negedge clk_core);
        check("wr1_busy", 32'(vram_busy), 32'd1);
        check("wr1_we_n", 32'(sram_we_n), 32'd1);
        check("wr1_hold", 32'({sram_addr, sram_dq}), 32'({18'h2, 16'h3C3C}));
        @(negedge clk_core);
        check("wr_busy_post", 32'(vram_busy), 32'd0);
        do_read(19'h00004);
        do_read(19'h00005);
        wait_drain();

        // Reads every cycle while the FIFO fills, forcing WGAP/WR0/WR1.
        busy_seq = 4'b1110; we_seq = 4'b1011; rdy_seq = 4'b0111;
        vram_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vram_addr  = {1'b1, 18'($urandom)};
            host_wr    = 1'b1;
            host_addr  = {1'b0, 18'($urandom)};
            host_wdata = 8'($urandom);
            wr_list.push_back(host_addr);
            @(negedge clk_core);
        end
        host_wr = 1'b0;
        check("full_ready", 32'(host_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            vram_addr = {1'b1, 18'($urandom)};
            @(negedge clk_core);
            check("force_busy", 32'(vram_busy), 32'(busy_seq[3-k]));
            check("force_we_n", 32'(sram_we_n), 32'(we_seq[3-k]));
            check("force_ready", 32'(host_ready), 32'(rdy_seq[3-k]));
        end
        for (int k = 0; k < 5; k++) begin
            vram_addr = {1'b1, 18'($urandom)};
            @(negedge clk_core);
        end
        vram_rd = 1'b0;
        repeat (15) @(negedge clk_core);
        wait_drain();

        // Randomized mix: reads in the upper half, writes in the lower half.
        for (int c = 0; c < 400; c++) begin
            vram_rd    = ($urandom_range(0, 99) < 70);
            vram_addr  = {1'b1, 18'($urandom)};
            host_wr    = ($urandom_range(0, 99) < 30);
            host_addr  = {1'b0, 18'($urandom)};
            host_wdata = 8'($urandom);
            if (host_wr && host_ready) wr_list.push_back(host_addr);
            @(negedge clk_core);
        end
        vram_rd = 1'b0;
        host_wr = 1'b0;
        repeat (20) @(negedge clk_core);
        foreach (wr_list[i]) do_read(wr_list[i]);
        wait_drain();

        // Write then read the same pixel and its neighbour.
        host_wr = 1'b1; host_addr = 19'h12345; host_wdata = 8'h81;
        @(negedge clk_core);
        host_wr = 1'b0;
        repeat (5) @(negedge clk_core);
        do_read(19'h12344);
        do_read(19'h12345);
        wait_drain();
        check("t5_data", 32'(vram_data), 32'h81);

        // Reset in the middle of WR0, with more writes still queued.
        vram_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t6_addr[k] = 19'h0AAA0 + 19'(k);
            vram_addr  = {1'b1, 18'($urandom)};
            host_wr    = 1'b1;
            host_addr  = t6_addr[k];
            host_wdata = 8'h96 + 8'(k);
            @(negedge clk_core);
        end
        vram_rd = 1'b0;
        host_wr = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && hit == 0; i++) begin
            @(negedge clk_core);
            if (!sram_we_n) hit = 1;
        end
        check("t6_reached_wr0", 32'(hit), 32'd1);
        #2;
        rst_core  = 1'b0;
        float_chk = 1'b1;
        #1;
        check("t6_we_n", 32'(sram_we_n), 32'd1);
        check("t6_ce_n", 32'(sram_ce_n), 32'd1);
        check("t6_dq_float", 32'(sram_dq), 32'd0);
        check("t6_ready", 32'(host_ready), 32'd1);
        check("t6_busy", 32'(vram_busy), 32'd0);
        check("t6_vld", 32'(vram_vld), 32'd0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) shadow.delete(int'(t6_addr[k]));
        repeat (2) @(negedge clk_core);
        rst_core  = 1'b1;
        float_chk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_core);
            check("t6_quiet", 32'({vram_vld, sram_we_n}), 32'b01);
        end
        for (int k = 0; k < 3; k++) do_read(t6_addr[k]);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
